// File: rtl/var_updown_counter.sv
// Variable-rate hex up/down counter feeding per-digit 7-segment decoders.
// Step every (DIV_BASE>>spd) enabled cycles; count/tick/wrap registered, no input-to-output path.
module var_updown_counter #(
  parameter int DIV_BASE = 50_000_000,
  parameter int DIGITS   = 2,
  localparam int W       = 4 * DIGITS,
  localparam int PW      = $clog2(DIV_BASE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic [1:0]   spd,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] count,
  output logic         tick,
  output logic         wrap
);

  logic [PW-1:0] r_pre;
  logic [W-1:0]  r_count;
  logic          r_tick;
  logic          r_wrap;

  logic [PW-1:0] w_term;
  logic          w_step;
  logic          w_wrap;
  logic [W-1:0]  w_next;

  always_comb begin
    w_term = PW'(DIV_BASE - 1);
    case (spd)
      2'd0: w_term = PW'((DIV_BASE >> 0) - 1);
      2'd1: w_term = PW'((DIV_BASE >> 1) - 1);
      2'd2: w_term = PW'((DIV_BASE >> 2) - 1);
      2'd3: w_term = PW'((DIV_BASE >> 3) - 1);
      default: w_term = PW'(DIV_BASE - 1);
    endcase
  end

  // >= so that lowering the rate below the current prescaler value steps immediately
  assign w_step = en && (r_pre >= w_term);
  assign w_next = up ? (r_count + W'(1)) : (r_count - W'(1));
  assign w_wrap = up ? (&r_count) : (~|r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_pre   <= '0;
      r_count <= din;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_pre   <= '0;
      r_count <= w_next;
      r_tick  <= 1'b1;
      r_wrap  <= w_wrap;
    end else begin
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      if (en) r_pre <= r_pre + PW'(1);
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_var_updown_counter.sv
// Directed bench for var_updown_counter with DIV_BASE=8, DIGITS=2.
module tb_var_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic [1:0] spd;
  logic       load;
  logic [7:0] din;
  logic [7:0] count;
  logic       tick;
  logic       wrap;

  int n_vec = 0;
  int n_err = 0;

  var_updown_counter #(.DIV_BASE(8), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .spd(spd),
    .load(load), .din(din), .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Edges until tick is seen; -1 if budget runs out.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    while (1) begin
      cyc();
      n++;
      if (tick) break;
      if (n >= budget) begin
        n = -1;
        break;
      end
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; spd = 2'd0; load = 1'b0; din = 8'h00;
    #1;
    chk("reset_count", count, 8'h00);
    chk("reset_tick", tick, 0);
    chk("reset_wrap", wrap, 0);
    cyc();
    rst = 1'b0;

    // 1: reset mid-run with count=37
    load = 1'b1; din = 8'h37;
    cyc();
    load = 1'b0; en = 1'b1;
    chk("t1_load37", count, 8'h37);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("t1_rst_count", count, 8'h00);
    chk("t1_rst_tick", tick, 0);
    chk("t1_rst_wrap", wrap, 0);
    #1;
    rst = 1'b0;
    wait_tick(20, n);
    chk("t1_first_tick_lat", n, 8);
    chk("t1_cnt01", count, 8'h01);
    chk("t1_wrap0", wrap, 0);

    // 2: spd=0 every 8, then spd=2 every 2
    cyc();
    chk("t2_tick_pulse", tick, 0);
    wait_tick(20, n);
    chk("t2_lat8_a", n, 7);
    chk("t2_cnt02", count, 8'h02);
    wait_tick(20, n);
    chk("t2_lat8_b", n, 8);
    chk("t2_cnt03", count, 8'h03);
    spd = 2'd2;
    wait_tick(20, n);
    chk("t2_lat2_a", n, 2);
    chk("t2_cnt04", count, 8'h04);
    wait_tick(20, n);
    chk("t2_lat2_b", n, 2);
    chk("t2_cnt05", count, 8'h05);

    // 3: load FE, count up across wrap at spd=3
    load = 1'b1; din = 8'hFE; spd = 2'd3; up = 1'b1;
    cyc();
    load = 1'b0;
    chk("t3_load_fe", count, 8'hFE);
    chk("t3_load_tick", tick, 0);
    cyc();
    chk("t3_cnt_ff", count, 8'hFF);
    chk("t3_tick_ff", tick, 1);
    chk("t3_wrap_ff", wrap, 0);
    cyc();
    chk("t3_cnt_00", count, 8'h00);
    chk("t3_tick_00", tick, 1);
    chk("t3_wrap_00", wrap, 1);
    cyc();
    chk("t3_cnt_01", count, 8'h01);
    chk("t3_wrap_01", wrap, 0);

    // 4: count down through zero
    up = 1'b0;
    cyc();
    chk("t4_cnt_00", count, 8'h00);
    chk("t4_wrap_00", wrap, 0);
    cyc();
    chk("t4_cnt_ff", count, 8'hFF);
    chk("t4_wrap_ff", wrap, 1);
    cyc();
    chk("t4_cnt_fe", count, 8'hFE);
    chk("t4_wrap_fe", wrap, 0);

    // 5: pre=6 at spd=0, then spd=2 steps on the next edge
    load = 1'b1; din = 8'h00; up = 1'b1; spd = 2'd0;
    cyc();
    load = 1'b0;
    chk("t5_load_00", count, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_no_tick", tick, 0);
    end
    spd = 2'd2;
    cyc();
    chk("t5_fast_tick", tick, 1);
    chk("t5_cnt01", count, 8'h01);
    wait_tick(20, n);
    chk("t5_lat2", n, 2);
    chk("t5_cnt02", count, 8'h02);

    // 6: load on a step cycle, then freeze
    cyc();
    chk("t6_pre_tick", tick, 0);
    load = 1'b1; din = 8'h55;
    cyc();
    load = 1'b0;
    chk("t6_load55", count, 8'h55);
    chk("t6_load_tick", tick, 0);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t6_hold_count", count, 8'h55);
      chk("t6_hold_tick", tick, 0);
    end
    en = 1'b1;
    wait_tick(20, n);
    chk("t6_resume_lat", n, 2);
    chk("t6_cnt56", count, 8'h56);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
